// File: rtl/calc_sequencer.sv
// Calculator control FSM: key events -> operand capture, adder drive, display/overflow select, receiver clear.
// Latency: outputs are registered one cycle after each key; the result is sampled RES_LAT cycles after ENTER.
// Backpressure: none; keys arriving in WAIT are dropped. Subtraction is enabled by CALC_SEQ_SUB_EN.
module calc_sequencer #(
    parameter int unsigned RES_LAT   = 1,
    parameter int unsigned TIMEOUT   = 50_000_000,
    parameter int unsigned CLR_PULSE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_vld_i,
    input  logic [3:0] key_code_i,
    input  logic [3:0] add_res_i,
    input  logic       add_cout_i,
    output logic [3:0] opa_o,
    output logic [3:0] opb_o,
    output logic       add_cin_o,
    output logic [3:0] disp_val_o,
    output logic       ovf_o,
    output logic       rx_clear_o,
    output logic [2:0] state_o
);

    localparam int unsigned LW = $clog2(RES_LAT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW = (CLR_PULSE < 1) ? 1 : $clog2(CLR_PULSE + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OP1   = 3'd1,
        S_OPSEL = 3'd2,
        S_OP2   = 3'd3,
        S_WAIT  = 3'd4,
        S_SHOW  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      opa_q, opa_d, opb_q, opb_d, disp_q, disp_d;
    logic            cin_q, cin_d, ovf_q, ovf_d, sub_q, sub_d, rx_clear_q, rx_clear_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [CW-1:0]   clr_cnt_q, clr_cnt_d;

    logic key_digit, key_enter, key_clear, key_plus, key_minus;
    logic tmo_armed, tmo_hit, clr_evt, lat_done;

    assign key_digit = key_vld_i && (key_code_i <= 4'd9);
    assign key_enter = key_vld_i && (key_code_i == 4'hA);
    assign key_clear = key_vld_i && (key_code_i == 4'hB);
    assign key_plus  = key_vld_i && (key_code_i == 4'hC);
`ifdef CALC_SEQ_SUB_EN
    assign key_minus = key_vld_i && (key_code_i == 4'hD);
`else
    assign key_minus = 1'b0;
`endif

    // The inactivity timer only runs while the user is mid-entry or looking at a result.
    assign tmo_armed = (state_q == S_OP1) || (state_q == S_OPSEL) ||
                       (state_q == S_OP2) || (state_q == S_SHOW);
    assign tmo_hit   = tmo_armed && !key_vld_i && (tmo_q == TW'(TIMEOUT - 1));
    assign clr_evt   = key_clear || tmo_hit;
    assign lat_done  = (state_q == S_WAIT) && (lat_q == LW'(RES_LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr_evt) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (key_digit) state_d = S_OP1;
                S_OP1:   if (key_plus || key_minus) state_d = S_OPSEL;
                S_OPSEL: if (key_digit) state_d = S_OP2;
                S_OP2:   if (key_enter) state_d = S_WAIT;
                S_WAIT:  if (lat_done) state_d = S_SHOW;
                S_SHOW: begin
                    if (key_digit)                   state_d = S_OP1;
                    else if (key_plus || key_minus)  state_d = S_OPSEL;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        opa_d  = opa_q;
        opb_d  = opb_q;
        cin_d  = cin_q;
        disp_d = disp_q;
        ovf_d  = ovf_q;
        sub_d  = sub_q;
        if (clr_evt) begin
            opa_d  = 4'd0;
            opb_d  = 4'd0;
            cin_d  = 1'b0;
            disp_d = 4'd0;
            ovf_d  = 1'b0;
            sub_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_OP1: begin
                    if (key_digit) begin
                        opa_d  = key_code_i;
                        disp_d = key_code_i;
                    end else if (state_q == S_OP1 && (key_plus || key_minus)) begin
                        sub_d = key_minus;
                    end
                end
                S_OPSEL, S_OP2: begin
                    // Subtraction is a + ~b + 1, so operand 2 is stored already inverted.
                    if (key_digit) begin
                        opb_d  = sub_q ? ~key_code_i : key_code_i;
                        disp_d = key_code_i;
                    end else if (state_q == S_OP2 && key_enter) begin
                        cin_d = sub_q;
                    end
                end
                S_WAIT: begin
                    if (lat_done) begin
                        disp_d = add_res_i;
                        ovf_d  = add_cout_i ^ sub_q;
                    end
                end
                S_SHOW: begin
                    if (key_digit) begin
                        opa_d  = key_code_i;
                        disp_d = key_code_i;
                        ovf_d  = 1'b0;
                    end else if (key_plus || key_minus) begin
                        opa_d = disp_q;
                        sub_d = key_minus;
                    end
                end
                default: ;
            endcase
        end

        lat_d = (state_q == S_WAIT) ? lat_q + LW'(1) : '0;
        tmo_d = (key_vld_i || clr_evt || !tmo_armed) ? '0 : tmo_q + TW'(1);

        if (clr_evt || (state_q == S_WAIT && state_d == S_SHOW)) clr_cnt_d = CW'(CLR_PULSE);
        else if (clr_cnt_q != '0)                                 clr_cnt_d = clr_cnt_q - CW'(1);
        else                                                      clr_cnt_d = '0;
        rx_clear_d = (clr_cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q      <= 4'd0;
            opb_q      <= 4'd0;
            cin_q      <= 1'b0;
            disp_q     <= 4'd0;
            ovf_q      <= 1'b0;
            sub_q      <= 1'b0;
            lat_q      <= '0;
            tmo_q      <= '0;
            clr_cnt_q  <= '0;
            rx_clear_q <= 1'b1;
        end else begin
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            cin_q      <= cin_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            sub_q      <= sub_d;
            lat_q      <= lat_d;
            tmo_q      <= tmo_d;
            clr_cnt_q  <= clr_cnt_d;
            rx_clear_q <= rx_clear_d;
        end
    end

    assign opa_o      = opa_q;
    assign opb_o      = opb_q;
    assign add_cin_o  = cin_q;
    assign disp_val_o = disp_q;
    assign ovf_o      = ovf_q;
    assign rx_clear_o = rx_clear_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed table, corner sequences and random keys against a reference model.
module tb_calc_sequencer;

    localparam int unsigned RES_LAT   = 1;
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned CLR_PULSE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_vld = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] add_res;
    logic       add_cout;
    logic [3:0] opa, opb, disp_val;
    logic       add_cin, ovf, rx_clear;
    logic [2:0] state_o;
    logic [4:0] sum5;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign sum5     = {1'b0, opa} + {1'b0, opb} + {4'd0, add_cin};
    assign add_res  = sum5[3:0];
    assign add_cout = sum5[4];

    calc_sequencer #(.RES_LAT(RES_LAT), .TIMEOUT(TIMEOUT), .CLR_PULSE(CLR_PULSE)) dut (
        .clk(clk), .rst_n(rst_n), .key_vld_i(key_vld), .key_code_i(key_code),
        .add_res_i(add_res), .add_cout_i(add_cout), .opa_o(opa), .opb_o(opb),
        .add_cin_o(add_cin), .disp_val_o(disp_val), .ovf_o(ovf),
        .rx_clear_o(rx_clear), .state_o(state_o)
    );

    // Reference model: states 0 IDLE, 1 OP1, 2 OPSEL, 3 OP2, 4 WAIT, 5 SHOW.
    int         m_st, m_w, m_t, m_clr;
    logic [3:0] m_a, m_b, m_bd, m_disp;
    logic       m_ovf, m_sub, m_cin, m_rx;

    function automatic void model_reset();
        m_st = 0; m_w = 0; m_t = 0; m_clr = 0;
        m_a = 0; m_b = 0; m_bd = 0; m_disp = 0;
        m_ovf = 0; m_sub = 0; m_cin = 0; m_rx = 1;
    endfunction

    function automatic void model_step(input logic v, input logic [3:0] c);
        logic dig, plus, minus, enter, clear, fire, pulse, was_active;
        int r;
        dig   = v && (c <= 4'd9);
        plus  = v && (c == 4'hC);
`ifdef CALC_SEQ_SUB_EN
        minus = v && (c == 4'hD);
`else
        minus = 1'b0;
`endif
        enter = v && (c == 4'hA);
        clear = v && (c == 4'hB);
        was_active = (m_st == 1) || (m_st == 2) || (m_st == 3) || (m_st == 5);
        fire  = was_active && !v && (m_t + 1 == int'(TIMEOUT));
        pulse = 1'b0;
        if (clear || fire) begin
            m_st = 0; m_a = 0; m_b = 0; m_bd = 0; m_disp = 0;
            m_ovf = 0; m_sub = 0; m_cin = 0; pulse = 1'b1;
        end else begin
            case (m_st)
                0: if (dig) begin m_a = c; m_disp = c; m_st = 1; end
                1: begin
                    if (dig) begin m_a = c; m_disp = c; end
                    else if (plus || minus) begin m_sub = minus; m_st = 2; end
                end
                2, 3: begin
                    if (dig) begin
                        m_bd = c; m_b = m_sub ? ~c : c; m_disp = c; m_st = 3;
                    end else if (m_st == 3 && enter) begin
                        m_cin = m_sub; m_st = 4; m_w = 0;
                    end
                end
                4: begin
                    if (m_w == int'(RES_LAT) - 1) begin
                        r = m_sub ? int'(m_a) - int'(m_bd) : int'(m_a) + int'(m_bd);
                        m_ovf  = m_sub ? (r < 0) : (r > 15);
                        m_disp = 4'(r & 15);
                        m_st = 5; pulse = 1'b1;
                    end else begin
                        m_w++;
                    end
                end
                5: begin
                    if (dig) begin m_a = c; m_disp = c; m_ovf = 0; m_st = 1; end
                    else if (plus || minus) begin m_a = m_disp; m_sub = minus; m_st = 2; end
                end
                default: ;
            endcase
        end
        m_t = (v || clear || fire || !was_active) ? 0 : m_t + 1;
        if (pulse) m_clr = int'(CLR_PULSE);
        else if (m_clr > 0) m_clr--;
        m_rx = (m_clr > 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] c);
        @(negedge clk);
        key_vld  = v;
        key_code = c;
        @(posedge clk);
        model_step(v, c);
        #1;
        key_vld = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("reset state", 32'(state_o), 32'd0);
        chk("reset operands", {24'd0, opa, opb}, 32'd0);
        chk("reset cin/disp/ovf", {26'd0, add_cin, disp_val, ovf}, 32'd0);
        chk("reset rx_clear high", 32'(rx_clear), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step(1'b0, 4'd0);
        #1;
        chk("post-reset rx_clear low", {28'd0, state_o, rx_clear}, 32'd0);
    endtask

    task automatic cmp_model(input string nm);
        chk(nm, {13'd0, state_o, opa, opb, add_cin, disp_val, ovf, rx_clear},
                {13'd0, 3'(m_st), m_a, m_b, m_cin, m_disp, m_ovf, m_rx});
    endtask

    typedef struct {
        logic       vld;
        logic [3:0] code;
        logic [2:0] st;
        logic [3:0] disp;
        logic       ovf;
        logic       rx;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{1'b1, 4'h3, 3'd1, 4'h3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hE, 3'd1, 4'h3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hA, 3'd1, 4'h3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hC, 3'd2, 4'h3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h4, 3'd3, 4'h4, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hA, 3'd4, 4'h4, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 3'd5, 4'h7, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 3'd5, 4'h7, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 3'd5, 4'h7, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hB, 3'd0, 4'h0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'h9, 3'd1, 4'h9, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'hC, 3'd2, 4'h9, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h8, 3'd3, 4'h8, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hA, 3'd4, 4'h8, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 3'd5, 4'h1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 4'hC, 3'd2, 4'h1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 4'h2, 3'd3, 4'h2, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'hA, 3'd4, 4'h2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 3'd5, 4'h3, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'hF, 3'd5, 4'h3, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 3'd5, 4'h3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hB, 3'd0, 4'h0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'h9, 3'd1, 4'h9, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'hC, 3'd2, 4'h9, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h6, 3'd3, 4'h6, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hA, 3'd4, 4'h6, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 3'd5, 4'hF, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'hC, 3'd2, 4'hF, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'h1, 3'd3, 4'h1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hA, 3'd4, 4'h1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 3'd5, 4'h0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 4'h7, 3'd1, 4'h7, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 3'd1, 4'h7, 1'b0, 1'b0});

        do_reset();

        foreach (tbl[i]) begin
            step(tbl[i].vld, tbl[i].code);
            chk($sformatf("table row %0d st/disp/ovf/rx", i),
                {20'd0, state_o, disp_val, ovf, rx_clear},
                {20'd0, tbl[i].st, tbl[i].disp, tbl[i].ovf, tbl[i].rx});
        end

        // Reset in the middle of operand 2 entry.
        step(1'b1, 4'hB);
        step(1'b1, 4'h3);
        step(1'b1, 4'hC);
        step(1'b1, 4'h4);
        chk("pre-reset OP2 opa/opb/state", {21'd0, state_o, opa, opb}, {21'd0, 3'd3, 4'h3, 4'h4});
        do_reset();

`ifdef CALC_SEQ_SUB_EN
        step(1'b1, 4'h2);
        step(1'b1, 4'hD);
        step(1'b1, 4'h5);
        chk("sub opb inverted", 32'(opb), 32'hA);
        step(1'b1, 4'hA);
        chk("sub cin/state", {28'd0, state_o, add_cin}, {28'd0, 3'd4, 1'b1});
        step(1'b0, 4'h0);
        chk("2-5 disp/ovf/state", {24'd0, state_o, disp_val, ovf}, {24'd0, 3'd5, 4'hD, 1'b1});
`else
        step(1'b1, 4'h2);
        step(1'b1, 4'hD);
        chk("minus ignored state/disp", {25'd0, state_o, disp_val}, {25'd0, 3'd1, 4'h2});
        step(1'b1, 4'h5);
        chk("minus ignored digit overwrite", {21'd0, state_o, opa, disp_val}, {21'd0, 3'd1, 4'h5, 4'h5});
`endif

        // CLEAR on the very cycle the adder result would have been captured.
        step(1'b1, 4'hB);
        step(1'b1, 4'h6);
        step(1'b1, 4'hC);
        step(1'b1, 4'h1);
        step(1'b1, 4'hA);
        chk("pre-clear WAIT", 32'(state_o), 32'd4);
        step(1'b1, 4'hB);
        chk("clear at WAIT end", {23'd0, state_o, disp_val, ovf, rx_clear}, {23'd0, 3'd0, 4'h0, 1'b0, 1'b1});
        step(1'b0, 4'h0);
        chk("result discarded", {21'd0, state_o, opa, disp_val}, 32'd0);

        // Inactivity timeout boundary.
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0);
        step(1'b1, 4'h5);
        for (int i = 0; i < 15; i++) step(1'b0, 4'h0);
        chk("timeout minus one still OP1", {25'd0, state_o, disp_val}, {25'd0, 3'd1, 4'h5});
        step(1'b0, 4'h0);
        chk("timeout to IDLE", {24'd0, state_o, disp_val, rx_clear}, {24'd0, 3'd0, 4'h0, 1'b1});

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [3:0] c;
            if ($urandom_range(0, 99) < 3) begin
                for (int k = 0; k < 20; k++) begin
                    step(1'b0, 4'h0);
                    cmp_model("random idle cycle");
                end
            end else begin
                r = int'($urandom_range(0, 19));
                if (r < 9 || r > 17) c = 4'($urandom_range(0, 9));
                else if (r < 11)     c = 4'hC;
                else if (r < 13)     c = 4'hD;
                else if (r < 16)     c = 4'hA;
                else if (r == 16)    c = ($urandom_range(0, 2) == 0) ? 4'hB : 4'hA;
                else                 c = 4'($urandom_range(14, 15));
                step($urandom_range(0, 99) < 65, c);
                cmp_model("random cycle");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
